// File: rtl/axi4_lite_timer_slave.sv
// AXI4-Lite responder exposing a 32-bit down-counting timer with a level interrupt.
// Map (addr[11:0]): 0x000 CTRL {IRQ_EN, RELOAD, EN}, 0x004 LOAD, 0x008 COUNT (RO),
// 0x00C STATUS {EXPIRED} write-1-to-clear. Anything else answers SLVERR.
module axi4_lite_timer_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic                    irq
);

    localparam logic [11:0] AddrCtrl   = 12'h000;
    localparam logic [11:0] AddrLoad   = 12'h004;
    localparam logic [11:0] AddrCount  = 12'h008;
    localparam logic [11:0] AddrStatus = 12'h00C;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlverr = 2'b10;

    // Only the low 12 address bits are decoded; the interconnect owns the base.
    logic unused_addr;
    assign unused_addr = ^{S_AXI_AWADDR[ADDR_WIDTH-1:12], S_AXI_ARADDR[ADDR_WIDTH-1:12]};

    // Holds all READY low until the first clock after reset release.
    logic running;

    logic        aw_held, w_held, bvalid, rvalid;
    logic [11:0] aw_addr;
    logic [31:0] w_data, rdata;
    logic [3:0]  w_strb;
    logic [1:0]  bresp, rresp;

    logic        en, reload, irq_en, expired;
    logic        en_d, reload_d, irq_en_d, expired_d;
    logic [31:0] load, count, load_d, count_d;

    logic        aw_hs, w_hs, ar_hs, wr_fire, wr_ok;
    logic [11:0] wr_addr;
    logic [31:0] wr_data, load_merged;
    logic [3:0]  wr_strb;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    assign S_AXI_AWREADY = running && !aw_held && !bvalid;
    assign S_AXI_WREADY  = running && !w_held && !bvalid;
    assign S_AXI_ARREADY = running && !rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A beat arriving this cycle is used directly so the write commits on this edge.
    assign wr_addr = aw_held ? aw_addr : S_AXI_AWADDR[11:0];
    assign wr_data = w_held ? w_data : S_AXI_WDATA;
    assign wr_strb = w_held ? w_strb : S_AXI_WSTRB;
    assign wr_fire = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_ok   = (wr_addr == AddrCtrl) || (wr_addr == AddrLoad) ||
                     (wr_addr == AddrCount) || (wr_addr == AddrStatus);

    // Byte-lane merge of the write data into LOAD.
    always_comb begin
        load_merged = load;
        for (int i = 0; i < 4; i++) begin
            if (wr_strb[i]) load_merged[8*i +: 8] = wr_data[8*i +: 8];
        end
    end

    // Timer next state; bus writes override the timer, expiry overrides W1C.
    always_comb begin
        en_d      = en;
        reload_d  = reload;
        irq_en_d  = irq_en;
        load_d    = load;
        count_d   = count;
        expired_d = expired;
        if (en) begin
            if (count != 32'd0) begin
                count_d = count - 32'd1;
            end else if (reload) begin
                count_d = load;
            end else begin
                en_d = 1'b0;
            end
        end
        if (wr_fire && wr_addr == AddrCtrl && wr_strb[0]) begin
            en_d     = wr_data[0];
            reload_d = wr_data[1];
            irq_en_d = wr_data[2];
        end
        if (wr_fire && wr_addr == AddrLoad) begin
            load_d  = load_merged;
            count_d = load_merged;
        end
        if (wr_fire && wr_addr == AddrStatus && wr_strb[0] && wr_data[0]) begin
            expired_d = 1'b0;
        end
        if (en && count == 32'd0) begin
            expired_d = 1'b1;
        end
    end

    // Read mux sampled at the AR handshake, so COUNT reads its pre-update value.
    always_comb begin
        rd_data = 32'd0;
        rd_resp = RespOkay;
        unique case (S_AXI_ARADDR[11:0])
            AddrCtrl:   rd_data = {29'd0, irq_en, reload, en};
            AddrLoad:   rd_data = load;
            AddrCount:  rd_data = count;
            AddrStatus: rd_data = {31'd0, expired};
            default:    rd_resp = RespSlverr;
        endcase
    end

    // Write channel: independent AW/W capture, commit and B response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= 12'd0;
            w_data  <= 32'd0;
            w_strb  <= 4'd0;
            bvalid  <= 1'b0;
            bresp   <= RespOkay;
        end else begin
            running <= 1'b1;
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= S_AXI_AWADDR[11:0];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (wr_fire) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_ok ? RespOkay : RespSlverr;
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read channel: register data on AR handshake, hold until RREADY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= 1'b0;
            rdata  <= 32'd0;
            rresp  <= RespOkay;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_data;
            rresp  <= rd_resp;
        end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

    // Timer registers and the registered interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en      <= 1'b0;
            reload  <= 1'b0;
            irq_en  <= 1'b0;
            load    <= 32'd0;
            count   <= 32'd0;
            expired <= 1'b0;
            irq     <= 1'b0;
        end else begin
            en      <= en_d;
            reload  <= reload_d;
            irq_en  <= irq_en_d;
            load    <= load_d;
            count   <= count_d;
            expired <= expired_d;
            irq     <= expired && irq_en;
        end
    end

endmodule

// File: doc/axi4_lite_timer_slave.md
Name: axi4_lite_timer_slave

Overview:
- AXI4-Lite responder (slave) holding a memory-mapped 32-bit down-counting timer with interrupt output.
- Sits on the SoC peripheral bus behind the same AXI4-Lite master the core uses for data accesses.
- Carries the full responder side of the protocol itself: independent AW/W capture, B response, AR/R response.
- Drives an interrupt line toward the core.

Parameters:
- ADDR_WIDTH, 32, AXI address width; only addr[11:0] is decoded, upper bits ignored (interconnect decodes base).
- DATA_WIDTH, 32, AXI data width; fixed at 32.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- S_AXI_AWADDR  input  ADDR_WIDTH  write address
- S_AXI_AWVALID  input  1  write address valid
- S_AXI_AWREADY  output  1  write address ready
- S_AXI_WDATA  input  32  write data
- S_AXI_WSTRB  input  4  write byte strobes
- S_AXI_WVALID  input  1  write data valid
- S_AXI_WREADY  output  1  write data ready
- S_AXI_BRESP  output  2  write response (00 OKAY, 10 SLVERR)
- S_AXI_BVALID  output  1  write response valid
- S_AXI_BREADY  input  1  write response ready
- S_AXI_ARADDR  input  ADDR_WIDTH  read address
- S_AXI_ARVALID  input  1  read address valid
- S_AXI_ARREADY  output  1  read address ready
- S_AXI_RDATA  output  32  read data
- S_AXI_RRESP  output  2  read response
- S_AXI_RVALID  output  1  read data valid
- S_AXI_RREADY  input  1  read data ready
- irq  output  1  timer interrupt, registered, level

Behaviour:
- Reset (rst=0, async): all READY, BVALID and RVALID are 0; BRESP, RRESP and RDATA are 0; irq is 0. All registers are 0.
- Register map (addr[11:0]):
  - 0x000 CTRL RW: bit0 EN, bit1 RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x004 LOAD RW.
  - 0x008 COUNT RO.
  - 0x00C STATUS: bit0 EXPIRED, write-1-to-clear.
- Address decode: any other addr[11:0], including unaligned addr[1:0]≠0, gives SLVERR. Reads of such addresses return 0; writes to them have no effect. A write to COUNT returns OKAY and is ignored.
- Write channel:
  - AWREADY=1 while no AW is captured and BVALID=0. WREADY=1 while no W is captured and BVALID=0.
  - AW and W are captured independently, in either order or in the same cycle.
  - The register update happens in the cycle after both are held. BVALID rises in that same cycle.
  - WSTRB applies per byte to CTRL and LOAD; STATUS uses only strobe bit0.
  - BVALID/BRESP are held until BREADY. No new AW/W is accepted while BVALID=1.
  - Minimum latency from the AW+W handshake cycle to BVALID is 1 cycle.
- Read channel:
  - ARREADY=1 while RVALID=0.
  - On the AR handshake, RDATA/RRESP are registered and RVALID=1 on the next cycle. They are held stable until RREADY.
  - The read channel is independent of the write channel; both may complete in the same cycle.
- Timer:
  - While EN=1 and COUNT≠0, COUNT decrements by 1 every cycle.
  - When EN=1 and COUNT==0: EXPIRED is set. If RELOAD=1, COUNT←LOAD. If RELOAD=0, EN is cleared (one-shot).
  - Writing LOAD (any strobe) also copies the new merged LOAD value into COUNT.
  - Writing CTRL with EN=1 while COUNT==0 expires on the following cycle.
- irq is registered from EXPIRED & IRQ_EN, so it lags by 1 cycle.
- Simultaneous events:
  - Expiry in the same cycle as a W1C of STATUS: set wins, EXPIRED stays 1.
  - LOAD write in the same cycle as an auto-reload: COUNT takes the newly written value.
  - LOAD write in the same cycle as a decrement: the write wins.
  - A read of COUNT returns its value in the AR handshake cycle (pre-update).
- Reset mid-transaction: all pending AW/W/B/R state is dropped immediately with no response issued. The master must be reset together with this block.

Test Plan:
- Write 0x0000_000A to 0x004 (WSTRB 1111), then read 0x004 → BRESP=00, RDATA=0x0000_000A, RRESP=00. Immediate read of 0x008 returns 0x0000_000A.
- W presented 3 cycles before AW for 0x000 data 0x7 → no BVALID until the cycle after AW handshake. Hold BREADY=0 for 4 cycles → BVALID and BRESP stay stable, AWREADY/WREADY stay 0.
- LOAD=5, CTRL=0x7 (EN, RELOAD, IRQ_EN) → COUNT sequence 5,4,3,2,1,0 then reloads to 5. EXPIRED=1 after the 0 cycle, irq=1 one cycle later. W1C 0x1 to 0x00C → irq drops.
- LOAD=3, CTRL=0x1 (one-shot) → COUNT reaches 0. CTRL reads 0x0 afterwards and COUNT stays 0. STATUS reads 0x1 and irq stays 0.
- Read 0x010 and write 0x002 → RRESP=10 with RDATA=0, BRESP=10. All registers unchanged.
- Partial strobe: LOAD=0xAABBCCDD, then write 0x11223344 with WSTRB 0101 → LOAD reads 0xAA22CC44. Also assert rst low during a pending BVALID → BVALID=0 and irq=0 immediately.
